// File: rtl/udp_frame_assembler.sv
// udp_frame_assembler
//   Takes one 64-bit UDP header per frame and emits it as two 32-bit
//   AXI-Stream beats. It then passes the payload stream through unchanged
//   until tlast. Payload bytes are counted, and a frame whose size disagrees
//   with the header's udp_length field is flagged with a one-cycle len_err
//   pulse.
//
// Parameters
//   LEN_CHECK     : 1 enables the length comparison, 0 ties len_err low
//
// Ports
//   clk, rstn     : clock and synchronous active-low reset
//   udp_header    : {src_port, dst_port, udp_length, checksum}, MSB-first
//   hdr_valid     : header handshake from the header builder
//   hdr_ready     : header handshake to the header builder
//   s_axis_*      : payload input stream (tdata[31:24] is the first byte)
//   m_axis_*      : assembled frame output stream
//   len_err       : pulses the cycle after a tlast handshake on a size mismatch
module udp_frame_assembler #(
  parameter bit LEN_CHECK = 1'b1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [63:0] udp_header,
  input  logic        hdr_valid,
  output logic        hdr_ready,
  input  logic [31:0] s_axis_tdata,
  input  logic [3:0]  s_axis_tkeep,
  input  logic        s_axis_tlast,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  output logic [31:0] m_axis_tdata,
  output logic [3:0]  m_axis_tkeep,
  output logic        m_axis_tlast,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        len_err
);

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned KEEP_W    = 4;
  localparam int unsigned CNT_W     = 16;
  localparam int unsigned POP_W     = 3;
  localparam int unsigned HDR_BYTES = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HDR0    = 2'd1,
    HDR1    = 2'd2,
    PAYLOAD = 2'd3
  } state_t;

  state_t             state;
  logic [63:0]        hdr_q;
  logic [CNT_W-1:0]   byte_cnt;

  logic               hdr_hs;
  logic               pay_hs;
  logic [POP_W-1:0]   keep_bytes;
  logic [CNT_W-1:0]   final_cnt;
  logic               len_mismatch;

  // Number of qualified bytes in one beat.
  function automatic logic [POP_W-1:0] popcount4(input logic [KEEP_W-1:0] k);
    popcount4 = POP_W'(k[0]) + POP_W'(k[1]) + POP_W'(k[2]) + POP_W'(k[3]);
  endfunction

  // Handshakes and the running length comparison.
  always_comb begin
    hdr_hs       = hdr_valid && (state == IDLE);
    pay_hs       = (state == PAYLOAD) && s_axis_tvalid && m_axis_tready;
    keep_bytes   = popcount4(s_axis_tkeep);
    final_cnt    = byte_cnt + CNT_W'(keep_bytes);
    // udp_length covers the 8-byte UDP header as well as the payload.
    len_mismatch = (final_cnt + CNT_W'(HDR_BYTES)) != hdr_q[31:16];
  end

  // Frame sequencing, header capture, byte counting and error pulse.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= IDLE;
      hdr_q    <= '0;
      byte_cnt <= '0;
      len_err  <= 1'b0;
    end else begin
      len_err <= 1'b0;
      case (state)
        IDLE: begin
          if (hdr_hs) begin
            hdr_q    <= udp_header;
            byte_cnt <= '0;
            state    <= HDR0;
          end
        end
        HDR0: begin
          if (m_axis_tready) state <= HDR1;
        end
        HDR1: begin
          if (m_axis_tready) state <= PAYLOAD;
        end
        PAYLOAD: begin
          if (pay_hs) begin
            byte_cnt <= final_cnt;
            if (s_axis_tlast) begin
              state   <= IDLE;
              len_err <= LEN_CHECK && len_mismatch;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output mux: header words from hdr_q, payload straight from the source.
  always_comb begin
    hdr_ready     = 1'b0;
    s_axis_tready = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tkeep  = '0;
    m_axis_tlast  = 1'b0;
    m_axis_tvalid = 1'b0;
    case (state)
      IDLE: begin
        hdr_ready = 1'b1;
      end
      HDR0: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = hdr_q[63:32];
        m_axis_tkeep  = {KEEP_W{1'b1}};
      end
      HDR1: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = hdr_q[DATA_W-1:0];
        m_axis_tkeep  = {KEEP_W{1'b1}};
      end
      PAYLOAD: begin
        s_axis_tready = m_axis_tready;
        m_axis_tvalid = s_axis_tvalid;
        m_axis_tdata  = s_axis_tdata;
        m_axis_tkeep  = s_axis_tkeep;
        m_axis_tlast  = s_axis_tlast;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_udp_frame_assembler.sv
module tb_udp_frame_assembler;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [63:0] udp_header = '0;
  logic        hdr_valid = 1'b0;
  logic [31:0] s_axis_tdata = '0;
  logic [3:0]  s_axis_tkeep = '0;
  logic        s_axis_tlast = 1'b0;
  logic        s_axis_tvalid = 1'b0;
  logic        m_axis_tready = 1'b1;

  logic        hdr_ready, s_axis_tready, m_axis_tlast, m_axis_tvalid, len_err;
  logic [31:0] m_axis_tdata;
  logic [3:0]  m_axis_tkeep;

  logic        hdr_ready_nc, s_axis_tready_nc, m_axis_tlast_nc, m_axis_tvalid_nc, len_err_nc;
  logic [31:0] m_axis_tdata_nc;
  logic [3:0]  m_axis_tkeep_nc;

  always #5 clk = ~clk;

  udp_frame_assembler #(.LEN_CHECK(1'b1)) dut (
    .clk(clk), .rstn(rstn), .udp_header(udp_header), .hdr_valid(hdr_valid),
    .hdr_ready(hdr_ready), .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
    .s_axis_tlast(s_axis_tlast), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .len_err(len_err)
  );

  udp_frame_assembler #(.LEN_CHECK(1'b0)) dut_nc (
    .clk(clk), .rstn(rstn), .udp_header(udp_header), .hdr_valid(hdr_valid),
    .hdr_ready(hdr_ready_nc), .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
    .s_axis_tlast(s_axis_tlast), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready_nc),
    .m_axis_tdata(m_axis_tdata_nc), .m_axis_tkeep(m_axis_tkeep_nc), .m_axis_tlast(m_axis_tlast_nc),
    .m_axis_tvalid(m_axis_tvalid_nc), .m_axis_tready(m_axis_tready), .len_err(len_err_nc)
  );

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } beat_t;

  beat_t exp_q[$];
  bit    err_q[$];
  int    checks = 0;
  int    fails = 0;
  int    cycle = 0;
  bit    bp_en = 1'b0;

  always @(posedge clk) cycle <= cycle + 1;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic void timeout(input string name);
    checks++;
    fails++;
    $display("FAIL %s: timed out waiting for handshake (t=%0t)", name, $time);
  endfunction

  // Downstream ready: constant 1, or a repeating 1,0,0,1 pattern.
  initial begin : ready_driver
    int idx;
    idx = 0;
    forever begin
      @(posedge clk);
      #1;
      if (bp_en) begin
        m_axis_tready = (idx % 4 == 0) || (idx % 4 == 3);
        idx++;
      end else begin
        m_axis_tready = 1'b1;
      end
    end
  end

  // Monitor: pops expected beats on each output handshake and checks len_err.
  initial begin : monitor
    bit          err_pend;
    bit          err_exp;
    bit          hold_pend;
    logic [31:0] hold_data;
    beat_t       e;
    err_pend  = 1'b0;
    err_exp   = 1'b0;
    hold_pend = 1'b0;
    hold_data = '0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        exp_q.delete();
        err_q.delete();
        err_pend  = 1'b0;
        hold_pend = 1'b0;
      end else begin
        if (err_pend) begin
          check("len_err_after_tlast", 32'(len_err), 32'(err_exp));
          err_pend = 1'b0;
        end else begin
          check("len_err_quiet", 32'(len_err), 32'd0);
        end
        check("len_err_disabled", 32'(len_err_nc), 32'd0);
        check("s_ready_without_m_ready", 32'(s_axis_tready && !m_axis_tready), 32'd0);
        if (hold_pend) begin
          check("hold_valid", 32'(m_axis_tvalid), 32'd1);
          check("hold_data", m_axis_tdata, hold_data);
          hold_pend = 1'b0;
        end
        if (m_axis_tvalid && m_axis_tready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_beat", m_axis_tdata, 32'hxxxx_xxxx);
          end else begin
            e = exp_q.pop_front();
            check("beat_data", m_axis_tdata, e.data);
            check("beat_keep", 32'(m_axis_tkeep), 32'(e.keep));
            check("beat_last", 32'(m_axis_tlast), 32'(e.last));
            check("nc_beat_valid", 32'(m_axis_tvalid_nc), 32'd1);
            check("nc_beat_data", m_axis_tdata_nc, e.data);
            check("nc_beat_last", 32'(m_axis_tlast_nc), 32'(e.last));
          end
          if (m_axis_tlast) begin
            if (err_q.size() == 0) begin
              check("unexpected_tlast", 32'(m_axis_tlast), 32'd0);
            end else begin
              err_exp  = err_q.pop_front();
              err_pend = 1'b1;
            end
          end
        end else if (m_axis_tvalid) begin
          hold_pend = 1'b1;
          hold_data = m_axis_tdata;
        end
      end
    end
  end

  // Tasks are entered 1 time unit after a rising edge and return likewise.
  task automatic send_header(input logic [63:0] h, output int acc_cycle);
    int n;
    n = 0;
    acc_cycle = -1;
    udp_header = h;
    hdr_valid  = 1'b1;
    forever begin
      #1;
      if (hdr_ready) begin
        exp_q.push_back('{data: h[63:32], keep: 4'hF, last: 1'b0});
        exp_q.push_back('{data: h[31:0],  keep: 4'hF, last: 1'b0});
        acc_cycle = cycle;
        @(posedge clk); #1;
        break;
      end
      n++;
      if (n > 200) begin
        timeout("header_accept");
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
    end
    hdr_valid = 1'b0;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l,
                           input bit exp_err, output int hs_cycle);
    int n;
    n = 0;
    hs_cycle = -1;
    s_axis_tdata  = d;
    s_axis_tkeep  = k;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    forever begin
      #1;
      if (s_axis_tready) begin
        exp_q.push_back('{data: d, keep: k, last: l});
        if (l) err_q.push_back(exp_err);
        hs_cycle = cycle;
        @(posedge clk); #1;
        break;
      end
      n++;
      if (n > 200) begin
        timeout("payload_accept");
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic send_frame(input logic [63:0] h, input logic [31:0] d0, input logic [31:0] d1,
                            input int nbeats, input logic [3:0] last_keep, input bit exp_err);
    int c;
    send_header(h, c);
    if (nbeats == 1) begin
      send_beat(d0, last_keep, 1'b1, exp_err, c);
    end else begin
      send_beat(d0, 4'hF, 1'b0, 1'b0, c);
      send_beat(d1, last_keep, 1'b1, exp_err, c);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_hdr_ready"}, 32'(hdr_ready), 32'd1);
    check({tag, "_s_tready"},  32'(s_axis_tready), 32'd0);
    check({tag, "_m_tvalid"},  32'(m_axis_tvalid), 32'd0);
    check({tag, "_m_tdata"},   m_axis_tdata, 32'd0);
    check({tag, "_m_tkeep"},   32'(m_axis_tkeep), 32'd0);
    check({tag, "_m_tlast"},   32'(m_axis_tlast), 32'd0);
    check({tag, "_len_err"},   32'(len_err), 32'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int c1, c2, c_last, c_unused;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rstn = 1'b1;
    @(posedge clk); #1;

    // Basic frame: 8 payload bytes + 8 = 0x10.
    send_frame(64'h1234_5678_0010_0000, 32'hAABB_CCDD, 32'h1122_3344, 2, 4'hF, 1'b0);
    // Single partial last beat: 3 bytes + 8 = 11 matches 0x000B.
    send_frame(64'h1234_5678_000B_0000, 32'h9988_7766, 32'h0, 1, 4'b1110, 1'b0);
    // Same beat against 0x000C: mismatch.
    send_frame(64'h1234_5678_000C_0000, 32'h9988_7766, 32'h0, 1, 4'b1110, 1'b1);
    // Full beat plus tkeep 1110: 7 bytes + 8 = 15.
    send_frame(64'hCAFE_0001_000F_BEEF, 32'hDEAD_BEEF, 32'hCAFE_BA00, 2, 4'b1110, 1'b0);
    // Full beat plus tkeep 1000: 5 bytes + 8 = 13 against 0x000E: mismatch.
    send_frame(64'h0A0B_0C0D_000E_0102, 32'h0102_0304, 32'h0500_0000, 2, 4'b1000, 1'b1);
    // Full beat plus tkeep 1100: 6 bytes + 8 = 14.
    send_frame(64'h0A0B_0C0D_000E_0102, 32'h0102_0304, 32'h0506_0000, 2, 4'b1100, 1'b0);

    // Back-pressure with ready pattern 1,0,0,1.
    bp_en = 1'b1;
    send_frame(64'hA1A2_B1B2_0010_FFFF, 32'h0102_0304, 32'h0506_0708, 2, 4'hF, 1'b0);
    bp_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Back-to-back: second header pending during frame 1.
    fork
      begin
        send_header(64'h0001_0002_0010_0000, c1);
        send_header(64'h0003_0004_000C_0000, c2);
      end
      begin
        send_beat(32'h1000_0001, 4'hF, 1'b0, 1'b0, c_unused);
        send_beat(32'h1000_0002, 4'hF, 1'b1, 1'b0, c_last);
        send_beat(32'h2000_0001, 4'hF, 1'b1, 1'b0, c_unused);
      end
    join
    check("bubble_cycles", 32'(c2 - c_last), 32'd1);

    // Reset in the middle of a payload.
    send_header(64'h5555_6666_0014_ABCD, c_unused);
    send_beat(32'h3000_0001, 4'hF, 1'b0, 1'b0, c_unused);
    s_axis_tdata  = 32'h3000_0002;
    s_axis_tkeep  = 4'hF;
    s_axis_tvalid = 1'b1;
    rstn = 1'b0;
    @(posedge clk); #1;
    check_idle_outputs("midreset");
    rstn = 1'b1;
    s_axis_tvalid = 1'b0;
    @(posedge clk); #1;
    send_frame(64'h0BAD_F00D_0010_1234, 32'h4000_0001, 32'h4000_0002, 2, 4'hF, 1'b0);

    repeat (4) @(posedge clk);
    #1;
    check("queue_drain", 32'(exp_q.size()), 32'd0);
    check("err_queue_drain", 32'(err_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
